// File: rtl/policy_table_loader_if.sv
// Byte-stream input and RAM write port of the policy table loader.
interface policy_table_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 2
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );
endinterface

// File: rtl/policy_table_loader.sv
// Unpacks a byte stream of 2-bit actions into the policy RAM, address 0 upward.
// State | meaning: IDLE wait for start | LOAD accept one byte | UNPACK write lanes | DONE table complete
module policy_table_loader #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 2,
    parameter int TABLE_DEPTH = 59049,
    parameter int LANES       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    policy_table_loader_if.slave  bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            checksum_o
);
    localparam int                LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(TABLE_DEPTH);
    localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, UNPACK, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [LW-1:0]     lane_q;
    logic [7:0]        buf_q;
    logic [7:0]        checksum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              busy_q;
    logic              done_q;
    logic [LW-1:0]     lane_d;
    logic [DATA_W-1:0] din_d;

    always_comb begin
        lane_d = lane_q + LW'(1);
        din_d  = buf_q[DATA_W*lane_d +: DATA_W];
    end

    // Lane 0 is written straight from in_data so the first write lands the cycle after the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lane_q     <= '0;
            buf_q      <= '0;
            checksum_q <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= LOAD;
                        cnt_q      <= '0;
                        lane_q     <= '0;
                        checksum_q <= '0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        buf_q      <= bus.in_data;
                        checksum_q <= checksum_q + bus.in_data;
                        lane_q     <= '0;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= cnt_q;
                        mem_din_q  <= bus.in_data[DATA_W-1:0];
                        cnt_q      <= cnt_q + ADDR_W'(1);
                        state_q    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= DONE;
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (lane_q == LAST_LANE) begin
                        state_q  <= LOAD;
                        mem_we_q <= 1'b0;
                    end else begin
                        lane_q     <= lane_d;
                        mem_addr_q <= cnt_q;
                        mem_din_q  <= din_d;
                        cnt_q      <= cnt_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign checksum_o   = checksum_q;
endmodule

// File: tb/tb_policy_table_loader.sv
// Directed bench for policy_table_loader with a 9-entry table.
module tb_policy_table_loader;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         log_addr[$];
    int         log_din[$];

    policy_table_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif();

    policy_table_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TABLE_DEPTH(DEPTH), .LANES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bif.slave),
        .busy_o(busy), .done_o(done), .checksum_o(checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.mem_we === 1'b1) begin
            log_addr.push_back(int'(bif.mem_addr));
            log_din.push_back(int'(bif.mem_din));
        end
    end

    task automatic chk_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lane(input logic [7:0] b, input int k);
        logic [7:0] s;
        s = b >> (2 * k);
        return int'(s & 8'h03);
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int ok;
        bif.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (bif.in_ready === 1'b1) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
        chk_val("handshake", ok, 1);
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk_val("done_wait", seen, 1);
    endtask

    task automatic check_writes(input string tag, input int n,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bytes [3];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        chk_val({tag, "_count"}, log_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < log_addr.size()) begin
                chk_val({tag, "_addr"}, log_addr[i], i);
                chk_val({tag, "_data"}, log_din[i], exp_lane(bytes[i/4], i % 4));
            end
        end
    endtask

    initial begin
        int found;
        rst          = 1'b1;
        start        = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;

        // reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_val("idle_ready", int'(bif.in_ready), 0);
        chk_val("idle_we", int'(bif.mem_we), 0);
        chk_val("idle_addr", int'(bif.mem_addr), 0);
        chk_val("idle_din", int'(bif.mem_din), 0);
        chk_val("idle_busy", int'(busy), 0);
        chk_val("idle_done", int'(done), 0);
        chk_val("idle_sum", int'(checksum), 0);
        chk_val("idle_nowr", log_addr.size(), 0);

        // single byte, cycle-exact
        pulse_start();
        chk_val("s_ready", int'(bif.in_ready), 1);
        chk_val("s_busy", int'(busy), 1);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'hE4;
        @(negedge clk);
        bif.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_val("s_we", int'(bif.mem_we), 1);
            chk_val("s_addr", int'(bif.mem_addr), i);
            chk_val("s_din", int'(bif.mem_din), i);
            chk_val("s_ready_unpack", int'(bif.in_ready), 0);
            @(negedge clk);
        end
        chk_val("s_we_off", int'(bif.mem_we), 0);
        chk_val("s_back_load", int'(bif.in_ready), 1);
        chk_val("s_sum", int'(checksum), 'hE4);

        // full load, no gaps
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        pulse_start();
        send_byte(8'h1B, 0);
        send_byte(8'h1B, 0);
        send_byte(8'h03, 0);
        wait_done();
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h55;
        repeat (5) @(negedge clk);
        bif.in_valid = 1'b0;
        check_writes("full", 9, 8'h1B, 8'h1B, 8'h03);
        chk_val("full_done", int'(done), 1);
        chk_val("full_busy", int'(busy), 0);
        chk_val("full_ready", int'(bif.in_ready), 0);
        chk_val("full_sum", int'(checksum), 'h39);

        // restart from DONE with random input gaps
        clear_log();
        pulse_start();
        chk_val("re_done", int'(done), 0);
        chk_val("re_busy", int'(busy), 1);
        chk_val("re_sum", int'(checksum), 0);
        send_byte(8'h1B, int'($urandom_range(1, 4)));
        send_byte(8'h1B, int'($urandom_range(1, 4)));
        send_byte(8'h03, int'($urandom_range(1, 4)));
        wait_done();
        repeat (3) @(negedge clk);
        check_writes("gap", 9, 8'h1B, 8'h1B, 8'h03);
        chk_val("gap_sum", int'(checksum), 'h39);

        // start and in_valid during UNPACK are ignored
        clear_log();
        pulse_start();
        send_byte(8'hA5, 0);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bif.in_valid = 1'b0;
        @(negedge clk);
        chk_val("ign_ready", int'(bif.in_ready), 1);
        chk_val("ign_sum", int'(checksum), 'hA5);
        send_byte(8'h0F, 0);
        repeat (5) @(negedge clk);
        check_writes("ign", 8, 8'hA5, 8'h0F, 8'h00);
        chk_val("ign_sum2", int'(checksum), 'hB4);
        chk_val("ign_done", int'(done), 0);

        // reset mid-load right after address 5 is written
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        send_byte(8'h1B, 0);
        send_byte(8'h1B, 0);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (bif.mem_we === 1'b1 && bif.mem_addr == 16'd5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk_val("mid_addr5", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_val("mid_we", int'(bif.mem_we), 0);
        chk_val("mid_done", int'(done), 0);
        chk_val("mid_busy", int'(busy), 0);
        chk_val("mid_ready", int'(bif.in_ready), 0);
        chk_val("mid_sum", int'(checksum), 0);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_byte(8'h03, 0);
        repeat (6) @(negedge clk);
        check_writes("fresh", 4, 8'h03, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
